// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage. Byte/half/word loads and stores to a
// word-organised little-endian data memory, load extension, MEM/WB register,
// combinational debug read port and a sticky halt freeze.
// Latency: MEM/WB outputs are registered, 1 cycle after an enabled edge. The
// debug port is combinational.
// Backpressure: i_enable=0 or a latched halt holds MEM/WB and blocks stores.
// Ports: clk/reset (async active-low), EX/MEM inputs i_*, MEM/WB outputs o_*,
//   debug word index i_debug_addr -> o_debug_data.
module mem_stage #(
   parameter int DATA_DEPTH = 256,
   parameter int DADDR_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_enable,
   input  logic [31:0]           i_alu_result,
   input  logic [31:0]           i_write_data,
   input  logic [4:0]            i_write_register,
   input  logic                  i_reg_write,
   input  logic                  i_mem_to_reg,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic [1:0]            i_mem_size,
   input  logic                  i_mem_unsigned,
   input  logic                  i_is_halt,
   input  logic [DADDR_BITS-1:0] i_debug_addr,
   output logic [31:0]           o_debug_data,
   output logic [31:0]           o_alu_result,
   output logic [31:0]           o_read_data,
   output logic [4:0]            o_write_register,
   output logic                  o_reg_write,
   output logic                  o_mem_to_reg,
   output logic                  o_is_halt,
   output logic                  o_misaligned
);

   logic [31:0]           mem [DATA_DEPTH];
   logic                  halted;

   logic [DADDR_BITS-1:0] word_idx;
   logic [1:0]            lane;
   logic [4:0]            shamt;
   logic [31:0]           cur_word;
   logic [31:0]           lane_data;
   logic [31:0]           load_ext;
   logic [31:0]           load_data;
   logic [31:0]           store_mask;
   logic [31:0]           store_bits;
   logic [31:0]           new_word;
   logic                  misaligned;
   logic                  advance;
   logic                  store_en;

   // Upper address bits are ignored, so addresses wrap over the array.
   assign word_idx = i_alu_result[DADDR_BITS+1:2];
   assign lane     = i_alu_result[1:0];
   assign shamt    = {lane, 3'b000};
   assign cur_word = mem[word_idx];

   // Only real memory accesses can be misaligned; ALU ops pass untouched.
   // Size 2'b10 is handled as a word.
   always_comb begin
      misaligned = 1'b0;
      if (i_mem_read || i_mem_write) begin
         if (i_mem_size == 2'b01)
            misaligned = lane[0];
         else if (i_mem_size[1])
            misaligned = (lane != 2'b00);
      end
   end

   assign advance  = i_enable && !halted;
   assign store_en = advance && i_mem_write && !misaligned;

   // Load path: shift the addressed lane down to bit 0, then extend.
   assign lane_data = cur_word >> shamt;

   always_comb begin
      load_ext = cur_word;
      case (i_mem_size)
         2'b00: load_ext = i_mem_unsigned ? {24'd0, lane_data[7:0]}
                                          : {{24{lane_data[7]}}, lane_data[7:0]};
         2'b01: load_ext = i_mem_unsigned ? {16'd0, lane_data[15:0]}
                                          : {{16{lane_data[15]}}, lane_data[15:0]};
         default: load_ext = cur_word;
      endcase
   end

   // A combined read+write performs the store and returns zero load data.
   assign load_data = (i_mem_read && !i_mem_write && !misaligned) ? load_ext : 32'd0;

   // Store path: replicate the source across the word, then mask in the lanes.
   always_comb begin
      store_mask = 32'hFFFF_FFFF;
      store_bits = i_write_data;
      case (i_mem_size)
         2'b00: begin
            store_mask = 32'h0000_00FF << shamt;
            store_bits = {4{i_write_data[7:0]}};
         end
         2'b01: begin
            store_mask = 32'h0000_FFFF << shamt;
            store_bits = {2{i_write_data[15:0]}};
         end
         default: begin
            store_mask = 32'hFFFF_FFFF;
            store_bits = i_write_data;
         end
      endcase
   end

   assign new_word     = (cur_word & ~store_mask) | (store_bits & store_mask);
   assign o_debug_data = mem[i_debug_addr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DATA_DEPTH; i++)
            mem[i] <= 32'd0;
      end else if (store_en) begin
         mem[word_idx] <= new_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted           <= 1'b0;
         o_alu_result     <= 32'd0;
         o_read_data      <= 32'd0;
         o_write_register <= 5'd0;
         o_reg_write      <= 1'b0;
         o_mem_to_reg     <= 1'b0;
         o_is_halt        <= 1'b0;
         o_misaligned     <= 1'b0;
      end else if (advance) begin
         halted           <= i_is_halt;
         o_alu_result     <= i_alu_result;
         o_read_data      <= load_data;
         o_write_register <= i_write_register;
         o_reg_write      <= i_reg_write && !misaligned;
         o_mem_to_reg     <= i_mem_to_reg;
         o_is_halt        <= i_is_halt;
         o_misaligned     <= misaligned;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table of load/store vectors plus hand-written
// sequences for same-cycle debug reads, enable hold, halt freeze and reset.
// Inputs change on the falling edge; outputs are sampled after the rising edge.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_enable;
   logic [31:0] i_alu_result;
   logic [31:0] i_write_data;
   logic [4:0]  i_write_register;
   logic        i_reg_write;
   logic        i_mem_to_reg;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [1:0]  i_mem_size;
   logic        i_mem_unsigned;
   logic        i_is_halt;
   logic [7:0]  i_debug_addr;
   logic [31:0] o_debug_data;
   logic [31:0] o_alu_result;
   logic [31:0] o_read_data;
   logic [4:0]  o_write_register;
   logic        o_reg_write;
   logic        o_mem_to_reg;
   logic        o_is_halt;
   logic        o_misaligned;

   int checks   = 0;
   int failures = 0;

   mem_stage #(.DATA_DEPTH(256), .DADDR_BITS(8)) dut (
      .clk(clk), .reset(reset), .i_enable(i_enable),
      .i_alu_result(i_alu_result), .i_write_data(i_write_data),
      .i_write_register(i_write_register), .i_reg_write(i_reg_write),
      .i_mem_to_reg(i_mem_to_reg), .i_mem_read(i_mem_read),
      .i_mem_write(i_mem_write), .i_mem_size(i_mem_size),
      .i_mem_unsigned(i_mem_unsigned), .i_is_halt(i_is_halt),
      .i_debug_addr(i_debug_addr), .o_debug_data(o_debug_data),
      .o_alu_result(o_alu_result), .o_read_data(o_read_data),
      .o_write_register(o_write_register), .o_reg_write(o_reg_write),
      .o_mem_to_reg(o_mem_to_reg), .o_is_halt(o_is_halt),
      .o_misaligned(o_misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rw;
      logic [7:0]  dbg;
      logic [31:0] exp_rd;
      logic        exp_rw;
      logic        exp_mis;
      logic [31:0] exp_dbg;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz, logic uns,
                               logic [31:0] addr, logic [31:0] wdata, logic rw,
                               logic [7:0] dbg, logic [31:0] exp_rd,
                               logic exp_rw, logic exp_mis, logic [31:0] exp_dbg);
      vec_t v;
      v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
      v.wdata = wdata; v.rw = rw; v.dbg = dbg; v.exp_rd = exp_rd;
      v.exp_rw = exp_rw; v.exp_mis = exp_mis; v.exp_dbg = exp_dbg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rw, input logic halt,
                        input logic [4:0] wreg);
      i_enable = en; i_mem_read = rd; i_mem_write = wr; i_mem_size = sz;
      i_mem_unsigned = uns; i_alu_result = addr; i_write_data = wdata;
      i_reg_write = rw; i_is_halt = halt; i_write_register = wreg;
      i_mem_to_reg = rd;
   endtask

   initial begin
      //                rd wr  sz    u  addr          wdata         rw dbg  exp_rd        rw mis exp_dbg
      vecs[0]  = mk(0, 1, 2'b11, 0, 32'h10,  32'h8899AABB, 0, 4, 32'h0,        0, 0, 32'h8899AABB);
      vecs[1]  = mk(1, 0, 2'b00, 0, 32'h10,  32'h0,        1, 4, 32'hFFFFFFBB, 1, 0, 32'h8899AABB);
      vecs[2]  = mk(1, 0, 2'b00, 1, 32'h10,  32'h0,        1, 4, 32'h000000BB, 1, 0, 32'h8899AABB);
      vecs[3]  = mk(1, 0, 2'b01, 0, 32'h12,  32'h0,        1, 4, 32'hFFFF8899, 1, 0, 32'h8899AABB);
      vecs[4]  = mk(1, 0, 2'b01, 1, 32'h12,  32'h0,        1, 4, 32'h00008899, 1, 0, 32'h8899AABB);
      vecs[5]  = mk(1, 0, 2'b11, 0, 32'h10,  32'h0,        1, 4, 32'h8899AABB, 1, 0, 32'h8899AABB);
      vecs[6]  = mk(1, 0, 2'b00, 0, 32'h11,  32'h0,        1, 4, 32'hFFFFFFAA, 1, 0, 32'h8899AABB);
      vecs[7]  = mk(0, 1, 2'b00, 0, 32'h13,  32'h1234567F, 0, 4, 32'h0,        0, 0, 32'h7F99AABB);
      vecs[8]  = mk(0, 1, 2'b01, 0, 32'h10,  32'hABCD1234, 0, 4, 32'h0,        0, 0, 32'h7F991234);
      vecs[9]  = mk(0, 1, 2'b11, 0, 32'h11,  32'hFFFFFFFF, 1, 4, 32'h0,        0, 1, 32'h7F991234);
      vecs[10] = mk(1, 0, 2'b01, 0, 32'h11,  32'h0,        1, 4, 32'h0,        0, 1, 32'h7F991234);
      vecs[11] = mk(1, 0, 2'b11, 1, 32'h10,  32'h0,        1, 4, 32'h7F991234, 1, 0, 32'h7F991234);
      vecs[12] = mk(1, 0, 2'b01, 0, 32'h12,  32'h0,        1, 4, 32'h00007F99, 1, 0, 32'h7F991234);
      vecs[13] = mk(0, 1, 2'b11, 0, 32'h400, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF);
      vecs[14] = mk(1, 0, 2'b11, 0, 32'h400, 32'h0,        1, 0, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF);
      vecs[15] = mk(1, 1, 2'b11, 0, 32'h20,  32'h11223344, 1, 8, 32'h0,        1, 0, 32'h11223344);
      vecs[16] = mk(0, 0, 2'b00, 1, 32'h10,  32'h0,        1, 4, 32'h0,        1, 0, 32'h7F991234);
      vecs[17] = mk(1, 0, 2'b10, 0, 32'h20,  32'h0,        1, 8, 32'h11223344, 1, 0, 32'h11223344);
      vecs[18] = mk(1, 0, 2'b01, 1, 32'h22,  32'h0,        1, 8, 32'h00001122, 1, 0, 32'h11223344);
      vecs[19] = mk(1, 0, 2'b00, 0, 32'h23,  32'h0,        1, 8, 32'h00000011, 1, 0, 32'h11223344);
      vecs[20] = mk(0, 1, 2'b01, 0, 32'h13,  32'h0,        0, 4, 32'h0,        0, 1, 32'h7F991234);

      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      i_debug_addr = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_alu_result", o_alu_result, 32'h0);
      chk("rst_read_data", o_read_data, 32'h0);
      chk("rst_flags", {27'd0, o_reg_write, o_mem_to_reg, o_is_halt, o_misaligned, 1'b0}, 32'h0);
      chk("rst_write_register", {27'd0, o_write_register}, 32'h0);
      for (int a = 0; a < 256; a++) begin
         i_debug_addr = a[7:0];
         #1;
         chk($sformatf("rst_mem[%0d]", a), o_debug_data, 32'h0);
      end

      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         drive(1'b1, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
               vecs[i].wdata, vecs[i].rw, 1'b0, 5'(i + 1));
         @(posedge clk);
         #1;
         i_debug_addr = vecs[i].dbg;
         #1;
         chk($sformatf("v%0d read_data", i), o_read_data, vecs[i].exp_rd);
         chk($sformatf("v%0d reg_write", i), {31'd0, o_reg_write}, {31'd0, vecs[i].exp_rw});
         chk($sformatf("v%0d misaligned", i), {31'd0, o_misaligned}, {31'd0, vecs[i].exp_mis});
         chk($sformatf("v%0d alu_result", i), o_alu_result, vecs[i].addr);
         chk($sformatf("v%0d write_register", i), {27'd0, o_write_register}, 32'(i + 1));
         chk($sformatf("v%0d mem_to_reg", i), {31'd0, o_mem_to_reg}, {31'd0, vecs[i].rd});
         chk($sformatf("v%0d debug", i), o_debug_data, vecs[i].exp_dbg);
      end

      // Debug read of a word being stored shows the old value until the edge.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 5'd3);
      i_debug_addr = 8'd12;
      #1;
      chk("same_cycle_debug_old", o_debug_data, 32'h0);
      @(posedge clk);
      #1;
      chk("same_cycle_debug_new", o_debug_data, 32'hCAFEF00D);

      // Enable low: no store, MEM/WB holds.
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h34, 32'h00005555, 1'b1, 1'b0, 5'd9);
      i_debug_addr = 8'd13;
      @(posedge clk);
      #1;
      chk("disabled_no_store", o_debug_data, 32'h0);
      chk("disabled_hold_alu", o_alu_result, 32'h30);
      chk("disabled_hold_wreg", {27'd0, o_write_register}, 32'd3);

      // Halt freeze.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 32'h55, 32'h0, 1'b1, 1'b1, 5'd7);
      @(posedge clk);
      #1;
      chk("halt_is_halt", {31'd0, o_is_halt}, 32'd1);
      chk("halt_alu", o_alu_result, 32'h55);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd2);
      i_debug_addr = 8'd8;
      repeat (2) @(posedge clk);
      #1;
      chk("frozen_no_store", o_debug_data, 32'h11223344);
      chk("frozen_is_halt", {31'd0, o_is_halt}, 32'd1);
      chk("frozen_alu", o_alu_result, 32'h55);
      chk("frozen_wreg", {27'd0, o_write_register}, 32'd7);

      // Reset during the freeze clears flag, outputs and memory immediately.
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_is_halt", {31'd0, o_is_halt}, 32'd0);
      chk("midreset_alu", o_alu_result, 32'h0);
      chk("midreset_mem8", o_debug_data, 32'h0);
      i_debug_addr = 8'd4;
      #1;
      chk("midreset_mem4", o_debug_data, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      i_debug_addr = 8'd8;
      @(posedge clk);
      #1;
      chk("post_reset_store", o_debug_data, 32'hFFFFFFFF);
      chk("post_reset_is_halt", {31'd0, o_is_halt}, 32'd0);
      chk("post_reset_alu", o_alu_result, 32'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting between the EX/MEM register and the write-back stage. Performs byte/halfword/word loads and stores against a word-organised, little-endian data memory, sign- or zero-extends load data, and holds the MEM/WB pipeline register that feeds write-back. It also provides a debug read port into data memory and a sticky halt freeze.

## Interface
Parameters:
- DATA_DEPTH, 256, number of 32-bit words in data memory (power of two)
- DADDR_BITS, 8, log2(DATA_DEPTH)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance; 0 holds MEM/WB and blocks stores
- i_alu_result  in  32  byte address for loads/stores; passthrough for write-back
- i_write_data  in  32  store data (rt)
- i_write_register  in  5  destination register
- i_reg_write  in  1  register-write control
- i_mem_to_reg  in  1  write-back source select
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_mem_size  in  2  00 byte, 01 halfword, 11 word; 10 treated as word
- i_mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- i_is_halt  in  1  HALT marker travelling with the instruction
- i_debug_addr  in  DADDR_BITS  debug word index
- o_debug_data  out  32  combinational memory word at i_debug_addr
- o_alu_result  out  32  MEM/WB copy of i_alu_result
- o_read_data  out  32  MEM/WB extended load data
- o_write_register  out  5  MEM/WB copy
- o_reg_write  out  1  MEM/WB copy, forced 0 on misaligned access
- o_mem_to_reg  out  1  MEM/WB copy
- o_is_halt  out  1  MEM/WB copy of i_is_halt
- o_misaligned  out  1  MEM/WB flag: access was misaligned and was suppressed

## Operation
- Word index is i_alu_result[DADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap modulo DATA_DEPTH words. The byte lane is i_alu_result[1:0]; lane 0 occupies bits 7:0.
- Misaligned access is a halfword with addr[0]=1, or a word with addr[1:0]≠0. On a misaligned access:
  - the store is suppressed;
  - o_read_data is 0;
  - o_reg_write is 0;
  - o_misaligned is 1.
- Stores:
  - Byte: replaces only the lane selected by addr[1:0] with i_write_data[7:0].
  - Halfword: addr[1] selects bits 15:0 or 31:16, written with i_write_data[15:0].
  - Word: replaces the whole word.
- Loads: select the addressed lane(s), then extend to 32 bits. Sign-extend when i_mem_unsigned=0; zero-extend when i_mem_unsigned=1. Word loads ignore i_mem_unsigned. When i_mem_read=0, o_read_data is 0.
- i_mem_read and i_mem_write both 1: the store is performed and o_read_data is 0.
- Halt freeze: an internal sticky flag sets on the rising edge where i_enable=1 and i_is_halt=1. While the flag is set:
  - all stores are blocked;
  - the MEM/WB register holds, so o_is_halt stays 1.
  Only reset clears the flag.
- i_enable=0: no store, MEM/WB holds. The debug port remains live.
- Debug port: asynchronous read of the current array contents. It never writes.

## Timing
- Reset (asynchronous, active-low) drives:
  - every MEM/WB output to 0;
  - the halt flag to 0;
  - every memory word to 0.
  Deassertion takes effect at the next rising edge.
- A store commits on the rising edge where i_mem_write=1, i_enable=1, the access is aligned, and the halt flag is clear.
- MEM/WB latency is 1 cycle: outputs reflect the inputs present at the previous enabled rising edge.
- Load data is sampled from the array before the edge commits any store. A store in cycle N followed by a load to the same address in cycle N+1 returns the new data at N+2.
- o_debug_data addressing a word being stored in the same cycle shows the old value until the edge.

## Test plan
- Reset then release; sweep i_debug_addr 0..255 -> o_debug_data = 0 everywhere; all outputs 0.
- Store word 0x8899AABB at 0x10, then loads at 0x10: lb -> 0xFFFFFFBB, lbu -> 0x000000BB, lh at 0x12 -> 0xFFFF8899, lhu at 0x12 -> 0x00008899, lw -> 0x8899AABB, each one cycle after issue.
- Store byte 0x7F at 0x13 over 0x8899AABB -> word 0x7F99AABB. Store half 0x1234 at 0x10 -> word 0x7F991234.
- Store word at 0x11 with i_reg_write=1 -> memory unchanged, o_misaligned=1, o_reg_write=0, o_read_data=0.
- Address 0x400 (wraps to word 0) store 0xDEADBEEF -> o_debug_data at index 0 = 0xDEADBEEF.
- Issue HALT with i_enable=1, then a store to 0x20 -> o_is_halt=1 and held, word 8 unchanged. Assert reset mid-freeze -> flag, outputs and memory cleared.
